serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 4 +
 rtl/fa_cell.sv | 11 +
 rtl/serial_adder.sv | 85 ++++++++
 tb/tb_serial_adder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state type and encodings shared by serial_adder
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/fa_cell.sv
// fa_cell: 1-bit full adder used as the ripple element of each chunk
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: chunk-serial adder, BITS_PER_CYCLE bits per clock; SERIAL_ADDER_OVF_EN adds signed-overflow output ovf
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);
  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  if (WIDTH < 1 || BITS_PER_CYCLE < 1 || WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_cfg
    $error("serial_adder: WIDTH must be a positive multiple of BITS_PER_CYCLE");
  end
  state_t                    state;
  logic [WIDTH-1:0]          ra, rb, acc, acc_nx;
  logic                      carry;
  logic [CW-1:0]             cnt;
  logic [BITS_PER_CYCLE-1:0] s;
  logic [BITS_PER_CYCLE:0]   c;
  logic                      last;
  assign c[0] = carry;
  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_fa
    fa_cell u_fa (.a(ra[i]), .b(rb[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
  end
  // new chunk enters at the top so the LSB chunk ends up at bit 0 after N shifts
  assign acc_nx = (acc >> BITS_PER_CYCLE) | (WIDTH'(s) << (WIDTH - BITS_PER_CYCLE));
  assign last   = cnt == CW'(N - 1);
  // FSM, operand shifters, result assembly and registered outputs
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      carry <= 1'b0;
      cnt   <= '0;
      ra    <= '0;
      rb    <= '0;
      acc   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state == RUN) begin
        ra    <= ra >> BITS_PER_CYCLE;
        rb    <= rb >> BITS_PER_CYCLE;
        acc   <= acc_nx;
        carry <= c[BITS_PER_CYCLE];
        cnt   <= cnt + CW'(1);
        if (last) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          sum   <= acc_nx;
          cout  <= c[BITS_PER_CYCLE];
`ifdef SERIAL_ADDER_OVF_EN
          ovf   <= c[BITS_PER_CYCLE-1] ^ c[BITS_PER_CYCLE];
`endif
        end
      end else if (start) begin
        state <= RUN;
        busy  <= 1'b1;
        ra    <= a;
        rb    <= b;
        carry <= cin;
        cnt   <= '0;
      end else
        state <= IDLE;
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: three configurations (8/1, 1/1, 16/4) checked every cycle against a behavioural model
module tb_serial_adder;
  localparam int WD[3] = '{8, 1, 16};
  localparam int NN[3] = '{8, 1, 4};
  logic        clk = 1'b0;
  logic        rst_n;
  logic        st[3];
  logic [15:0] av[3], bv[3];
  logic        ci[3];
  logic        ob[3], od[3], oc[3];
  logic [16:0] os[3];
  logic [7:0]  s8;
  logic [0:0]  s1;
  logic [15:0] s16;
`ifdef SERIAL_ADDER_OVF_EN
  logic        oo[3];
  logic        mo[3], po[3];
`endif
  logic        mb[3], md[3], mc[3];
  logic [16:0] ms[3], pend[3];
  int          rem[3];
  int          total = 0, bad = 0;
  always #5 clk = ~clk;
  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u8 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .a(av[0][7:0]), .b(bv[0][7:0]), .cin(ci[0]),
    .busy(ob[0]), .done(od[0]), .sum(s8),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(oo[0]),
`endif
    .cout(oc[0]));
  serial_adder #(.WIDTH(1), .BITS_PER_CYCLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .a(av[1][0:0]), .b(bv[1][0:0]), .cin(ci[1]),
    .busy(ob[1]), .done(od[1]), .sum(s1),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(oo[1]),
`endif
    .cout(oc[1]));
  serial_adder #(.WIDTH(16), .BITS_PER_CYCLE(4)) u16 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .a(av[2]), .b(bv[2]), .cin(ci[2]),
    .busy(ob[2]), .done(od[2]), .sum(s16),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(oo[2]),
`endif
    .cout(oc[2]));
  assign os[0] = {9'd0, s8};
  assign os[1] = {16'd0, s1};
  assign os[2] = {1'b0, s16};
  function automatic logic [16:0] msk(int d);
    return (17'd1 << WD[d]) - 17'd1;
  endfunction
  function automatic logic [16:0] add_res(int d);
    return ({1'b0, av[d]} & msk(d)) + ({1'b0, bv[d]} & msk(d)) + {16'd0, ci[d]};
  endfunction
  task automatic chk(input string n, input int d, input logic [16:0] act, input logic [16:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%0h want=%0h at %0t", n, d, act, exp, $time);
    end
  endtask
  // model: an accepted start yields the arithmetic sum N cycles later; starts while busy are dropped
  always @(posedge clk)
    for (int d = 0; d < 3; d++)
      if (!rst_n) begin
        mb[d] <= 1'b0; md[d] <= 1'b0; ms[d] <= '0; mc[d] <= 1'b0; rem[d] <= 0;
`ifdef SERIAL_ADDER_OVF_EN
        mo[d] <= 1'b0;
`endif
      end else begin
        md[d] <= mb[d] && rem[d] == 1;
        if (mb[d]) begin
          rem[d] <= rem[d] - 1;
          if (rem[d] == 1) begin
            mb[d] <= 1'b0;
            ms[d] <= pend[d] & msk(d);
            mc[d] <= pend[d][WD[d]];
`ifdef SERIAL_ADDER_OVF_EN
            mo[d] <= po[d];
`endif
          end
        end else if (st[d]) begin
          mb[d]   <= 1'b1;
          rem[d]  <= NN[d];
          pend[d] <= add_res(d);
`ifdef SERIAL_ADDER_OVF_EN
          po[d]   <= av[d][WD[d]-1] == bv[d][WD[d]-1] && add_res(d)[WD[d]-1] != av[d][WD[d]-1];
`endif
        end
      end
  // compare every output of every instance against the model each cycle
  always @(negedge clk)
    for (int d = 0; d < 3; d++) begin
      chk("busy", d, {16'd0, ob[d]}, {16'd0, mb[d]});
      chk("done", d, {16'd0, od[d]}, {16'd0, md[d]});
      chk("sum", d, os[d], ms[d]);
      chk("cout", d, {16'd0, oc[d]}, {16'd0, mc[d]});
`ifdef SERIAL_ADDER_OVF_EN
      chk("ovf", d, {16'd0, oo[d]}, {16'd0, mo[d]});
`endif
    end
  task automatic go(input int d, input logic [15:0] x, input logic [15:0] y, input logic c);
    st[d] = 1'b1; av[d] = x; bv[d] = y; ci[d] = c;
    @(negedge clk);
    st[d] = 1'b0;
  endtask
  task automatic wait_done(input int d, output int n);
    n = 0;
    while (!od[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", d, {16'd0, od[d]}, 17'd1);
  endtask
  initial begin
    int n, cnt;
    logic [7:0] tsum, tcout;
    logic [16:0] lsum;
    tsum = 8'b1001_0110;
    tcout = 8'b1110_1000;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin st[d] = 1'b0; av[d] = '0; bv[d] = '0; ci[d] = 1'b0; end
    repeat (2) @(negedge clk);
    chk("rst_sum", 0, os[0], 17'd0);
    chk("rst_busy", 0, {16'd0, ob[0]}, 17'd0);
    rst_n = 1'b1;
    go(0, 16'hFF, 16'h01, 1'b0);
    wait_done(0, n);
    chk("lat_ff01", 0, 17'(n), 17'd8);
    chk("sum_ff01", 0, os[0], 17'h00);
    chk("cout_ff01", 0, {16'd0, oc[0]}, 17'd1);
    go(2, 16'h1234, 16'h0FFF, 1'b1);
    wait_done(2, n);
    chk("lat_w16", 2, 17'(n), 17'd4);
    chk("sum_w16", 2, os[2], 17'h2234);
    chk("cout_w16", 2, {16'd0, oc[2]}, 17'd0);
    for (int i = 0; i < 8; i++) begin
      go(1, {15'd0, i[2]}, {15'd0, i[1]}, i[0]);
      wait_done(1, n);
      chk("lat_fa", 1, 17'(n), 17'd1);
      chk("sum_fa", 1, os[1], {16'd0, tsum[i]});
      chk("cout_fa", 1, {16'd0, oc[1]}, {16'd0, tcout[i]});
    end
`ifdef SERIAL_ADDER_OVF_EN
    go(0, 16'h7F, 16'h01, 1'b0);
    wait_done(0, n);
    chk("ovf_7f01", 0, {16'd0, oo[0]}, 17'd1);
    chk("sum_7f01", 0, os[0], 17'h80);
`endif
    repeat (2) @(negedge clk);
    go(0, 16'h12, 16'h34, 1'b0);
    st[0] = 1'b1; av[0] = 16'h99; bv[0] = 16'h11; ci[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    cnt = 0;
    lsum = '0;
    repeat (12) begin
      @(negedge clk);
      if (od[0]) begin cnt++; lsum = os[0]; end
    end
    chk("ignore_cnt", 0, 17'(cnt), 17'd1);
    chk("ignore_sum", 0, lsum, 17'h46);
    st[0] = 1'b1; av[0] = 16'h01; bv[0] = 16'h02; ci[0] = 1'b0;
    @(negedge clk);
    wait_done(0, n);
    chk("b2b_sum1", 0, os[0], 17'h03);
    av[0] = 16'h05; bv[0] = 16'h06;
    @(negedge clk);
    chk("b2b_busy", 0, {16'd0, ob[0]}, 17'd1);
    st[0] = 1'b0;
    wait_done(0, n);
    chk("b2b_lat", 0, 17'(n), 17'd8);
    chk("b2b_sum2", 0, os[0], 17'h0B);
    go(0, 16'h55, 16'h0F, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0; st[0] = 1'b1;
    @(negedge clk);
    chk("abort_busy", 0, {16'd0, ob[0]}, 17'd0);
    chk("abort_sum", 0, os[0], 17'd0);
    rst_n = 1'b1; st[0] = 1'b0;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (od[0]) cnt++;
    end
    chk("abort_nodone", 0, 17'(cnt), 17'd0);
    repeat (600) begin
      for (int d = 0; d < 3; d++) begin
        st[d] = $urandom_range(0, 3) == 0;
        av[d] = 16'($urandom);
        bv[d] = 16'($urandom);
        ci[d] = 1'($urandom);
      end
      rst_n = $urandom_range(0, 80) != 0;
      @(negedge clk);
    end
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) st[d] = 1'b0;
    repeat (20) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
